// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcodes, status flags and opcode classification.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_ADC = 3'd5,
    OP_SBB = 3'd6,
    OP_SLT = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  // Arithmetic ops are the only ones that produce C/V and update the carry register.
  function automatic logic is_arith(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one result word plus Z/N/C/V for a single operand pair.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] y_c,
  output alu_flags_t       flags_c,
  output logic             carry_wr_c
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  alu_op_e          op;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [SUM_W-1:0] sum;
  logic             lt;

  // Effective addend and carry-in; subtraction is a + ~b + cin.
  always_comb begin
    op         = alu_op_e'(op_i);
    b_eff      = b_i;
    cin_eff    = 1'b0;
    carry_wr_c = is_arith(op);
    case (op)
      OP_SUB:  begin b_eff = ~b_i; cin_eff = 1'b1;  end
      OP_ADC:  cin_eff = cin_i;
      OP_SBB:  begin b_eff = ~b_i; cin_eff = cin_i; end
      default: ;
    endcase
  end

  assign sum = SUM_W'(a_i) + SUM_W'(b_eff) + SUM_W'(cin_eff);
  assign lt  = $signed(a_i) < $signed(b_i);

  // Result select and flag derivation; C/V are forced low for non-arithmetic ops.
  always_comb begin
    y_c = sum[MSB:0];
    case (op)
      OP_AND:  y_c = a_i & b_i;
      OP_OR:   y_c = a_i | b_i;
      OP_XOR:  y_c = a_i ^ b_i;
      OP_SLT:  y_c = WIDTH'(lt);
      default: ;
    endcase
    flags_c.z = (y_c == '0);
    flags_c.n = y_c[MSB];
    flags_c.c = carry_wr_c & sum[WIDTH];
    flags_c.v = carry_wr_c & (a_i[MSB] == b_eff[MSB]) & (y_c[MSB] != a_i[MSB]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds operands, S2 holds result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_z,
  output logic             out_n,
  output logic             out_c,
  output logic             out_v,
  output logic             carry_q
);

  logic             rdy_q;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  alu_flags_t       flags_q, flags_d;
  logic             carry_d;

  logic             s2_adv_c;
  logic             s1_adv_c;
  logic             accept_c;
  logic             xfer_c;
  logic [WIDTH-1:0] core_y_c;
  alu_flags_t       core_flags_c;
  logic             core_wr_c;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .op_i       (s1_op_q),
    .cin_i      (carry_q),
    .y_c        (core_y_c),
    .flags_c    (core_flags_c),
    .carry_wr_c (core_wr_c)
  );

  // Handshake; rdy_q keeps in_ready low until the first clock after reset release.
  assign s2_adv_c = !s2_valid_q || out_ready;
  assign s1_adv_c = !s1_valid_q || s2_adv_c;
  assign in_ready = rdy_q && s1_adv_c && !flush;
  assign accept_c = in_valid && in_ready;
  assign xfer_c   = s1_valid_q && s2_adv_c && !flush;

  // Next-state: hold by default, load on advance, flush empties both stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    flags_d    = flags_q;
    carry_d    = carry_q;

    if (s1_adv_c) begin
      s1_valid_d = accept_c;
    end
    if (accept_c) begin
      s1_a_d  = in_a;
      s1_b_d  = in_b;
      s1_op_d = in_op;
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
    end
    if (xfer_c) begin
      y_d     = core_y_c;
      flags_d = core_flags_c;
      if (core_wr_c) begin
        carry_d = core_flags_c.c;
      end
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      flags_q    <= '0;
      carry_q    <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      flags_q    <= flags_d;
      carry_q    <= carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = y_q;
  assign out_z     = flags_q.z;
  assign out_n     = flags_q.n;
  assign out_c     = flags_q.c;
  assign out_v     = flags_q.v;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 16-bit combinational ALU.
- Adds width generalisation, eight operations (including carry-chained ADC/SBB and signed compare), status flags, a persistent carry register, and valid/ready handshaking with full backpressure.
- Sits between operand sourcing logic and a result consumer, e.g. a register-file writeback or a streaming datapath; multiple words can be chained through ADC/SBB.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range is WIDTH >= 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_op  in  3  operation code (alu_pkg::alu_op_e)
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- out_y  out  WIDTH  result
- out_z  out  1  zero flag
- out_n  out  1  negative flag (MSB of out_y)
- out_c  out  1  carry / no-borrow flag
- out_v  out  1  signed overflow flag
- carry_q  out  1  current carry register value

Behaviour:
- Reset: asynchronous on rst_n low; all outputs are driven by registers.
  - s1_valid, s2_valid, carry_q, out_y and all flags go to 0.
  - in_ready is 0 while rst_n is low, and 1 in the first cycle after release.
- Opcodes:
  - 000 ADD: a+b
  - 001 SUB: a+~b+1
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 ADC: a+b+carry_q
  - 110 SBB: a+~b+carry_q
  - 111 SLT: y = {0..., signed(a)<signed(b)}
- Arithmetic width rules:
  - Sum is computed at WIDTH+1 bits; C is the bit-WIDTH carry-out.
  - For SUB/SBB, C=1 means no borrow.
  - V = (a[MSB]==b'[MSB]) && (y[MSB]!=a[MSB]), where b' is the effective addend.
  - Logic ops and SLT force C=0, V=0.
  - Z and N are always derived from y.
- Pipeline structure:
  - S1 registers a, b and op on input acceptance.
  - The combinational core evaluates between S1 and S2.
  - S2 registers y and flags.
- Latency: a beat accepted in cycle T (in_valid & in_ready) produces out_valid in cycle T+2 when there is no stall. Throughput is 1 beat per cycle.
- Handshake rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv && !flush
- Output stability: out_y and the flags hold stable while out_valid && !out_ready.
- Input beats are never dropped or duplicated, and order is preserved.
- Carry register:
  - carry_q updates only when an ADD/SUB/ADC/SBB beat moves S1->S2; it takes that beat's C.
  - Logic ops and SLT leave carry_q unchanged.
  - Because S1->S2 transfer is in order, an ADC/SBB always sees the carry from the previous arithmetic beat, including when the two are back-to-back.
- Flush:
  - Clears s1_valid and s2_valid in that cycle; carry_q is kept.
  - Any input presented during flush is not accepted.
  - flush with out_valid & out_ready in the same cycle: the beat counts as consumed.
- Reset mid-operation: in-flight beats are discarded and carry_q returns to 0.

Decomposition:
- Shared package alu_pkg holds:
  - OP_W = 3
  - enum alu_op_e {ADD, SUB, AND, OR, XOR, ADC, SBB, SLT}
  - struct alu_flags_t {z, n, c, v}
- Sub-module alu_core: purely combinational, parameter WIDTH.
  - Inputs: a, b, op, cin.
  - Outputs: y, flags, carry_wr (high for arithmetic ops).
- alu_pipe owns the two register stages, the handshake, flush and carry_q.

Test Plan:
- ADD 0xFFFF+0x0001 then back-to-back ADC 0x0000+0x0000 -> y=0x0000 Z=1 C=1 V=0, then y=0x0001 C=0; carry_q ends at 0.
- SUB 0x0005-0x0007 -> y=0xFFFE N=1 C=0. SUB 0x8000-0x0001 -> y=0x7FFF V=1 C=1.
- SBB after SUB 0x0000-0x0001 (carry_q=0): SBB 0x0005-0x0002 -> y=0x0002. SLT 0xFFFF vs 0x0001 -> y=0x0001, and carry_q is unchanged.
- Backpressure:
  - Stimulus: hold out_ready=0 and offer 3 beats.
  - in_ready drops after 2 accepts.
  - Release out_ready: results appear in order, one per cycle, with no loss.
- Flush with S1 and S2 both valid and carry_q=1 -> next cycle out_valid=0, carry_q=1. The next accepted ADC 0x0001+0x0001 -> 0x0003.
- Assert rst_n=0 mid-stream for 1 cycle -> out_valid=0 and carry_q=0 immediately (asynchronously). After release, in_ready=1 and a fresh ADD 0x1234+0x0001 returns 0x1235 two cycles after acceptance.
